// File: rtl/yuv422_pkg.sv
// Shared constants and pixel type for the 720->640 YUV 4:2:2 horizontal decimator.
package yuv422_pkg;
    localparam int          TV_IN_WIDTH    = 720;
    localparam int          VGA_OUT_WIDTH  = 640;
    localparam logic [7:0]  CHROMA_NEUTRAL = 8'h80;
    localparam int          X_W            = 10;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] c;
    } ycbcr_t;
endpackage

// File: rtl/yuv422_chroma_realign.sv
// Keeps the last Cb and Cr seen on the line and substitutes one of them whenever
// the output slot wants the other chroma type than the input pixel carries.
module yuv422_chroma_realign
    import yuv422_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_restart,
    input  logic       i_in_odd,
    input  logic       i_out_odd,
    input  logic [7:0] i_c,
    output logic [7:0] o_c
);
    logic [7:0] r_cb;
    logic [7:0] r_cr;
    logic [7:0] w_cb;
    logic [7:0] w_cr;

    // A restarting line sees neutral chroma, not leftovers from the previous line.
    assign w_cb = i_restart ? CHROMA_NEUTRAL : r_cb;
    assign w_cr = i_restart ? CHROMA_NEUTRAL : r_cr;

    always_comb begin
        o_c = i_c;
        if (i_in_odd != i_out_odd) begin
            o_c = i_out_odd ? w_cr : w_cb;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cb <= CHROMA_NEUTRAL;
            r_cr <= CHROMA_NEUTRAL;
        end else if (i_valid) begin
            if (i_in_odd) begin
                r_cr <= i_c;
                r_cb <= w_cb;
            end else begin
                r_cb <= i_c;
                r_cr <= w_cr;
            end
        end
    end
endmodule

// File: rtl/yuv422_hdecim.sv
// Horizontal 720->640 decimator: drops one pixel in DROP_PERIOD and keeps the Cb/Cr
// alternation legal. Define YUV422_HDECIM_AVG_EN to blend each dropped Y into its predecessor.
module yuv422_hdecim
    import yuv422_pkg::*;
#(
    parameter int IN_WIDTH    = TV_IN_WIDTH,
    parameter int DROP_PERIOD = 9,
    parameter int OUT_WIDTH   = VGA_OUT_WIDTH
)
(
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSOL,
    input  logic            iDVAL,
    input  logic [15:0]     iYCbCr,
    output logic [15:0]     oYCbCr,
    output logic            oDVAL,
    output logic [X_W-1:0]  oX,
    output logic            oLINE_DONE
);
    localparam logic [X_W-1:0] IN_LIM    = X_W'(IN_WIDTH);
    localparam logic [X_W-1:0] DROP_LAST = X_W'(DROP_PERIOD - 1);
    localparam logic [X_W-1:0] OUT_LAST  = X_W'(OUT_WIDTH - 1);

    logic           r_sol_pend;
    logic [X_W-1:0] r_in_x;
    logic [X_W-1:0] r_phase;
    logic [X_W-1:0] r_out_x;

    logic           w_restart;
    logic [X_W-1:0] w_in_x;
    logic [X_W-1:0] w_phase;
    logic [X_W-1:0] w_out_x;
    logic           w_acc;
    logic           w_drop;
    logic           w_keep;
    logic [7:0]     w_c;
    ycbcr_t         w_pix;

    assign w_pix     = iYCbCr;
    assign w_restart = iDVAL && (iSOL || r_sol_pend);
    assign w_in_x    = w_restart ? '0 : r_in_x;
    assign w_phase   = w_restart ? '0 : r_phase;
    assign w_out_x   = w_restart ? '0 : r_out_x;
    assign w_acc     = iDVAL && (w_in_x < IN_LIM);
    assign w_drop    = (w_phase == DROP_LAST);
    assign w_keep    = w_acc && !w_drop;

    yuv422_chroma_realign u_realign (
        .i_clk     (iCLK),
        .i_rst     (iRST),
        .i_valid   (w_acc),
        .i_restart (w_restart),
        .i_in_odd  (w_in_x[0]),
        .i_out_odd (w_out_x[0]),
        .i_c       (w_pix.c),
        .o_c       (w_c)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_sol_pend <= 1'b0;
            r_in_x     <= '0;
            r_phase    <= '0;
            r_out_x    <= '0;
        end else begin
            if (iDVAL) begin
                r_sol_pend <= 1'b0;
            end else if (iSOL) begin
                r_sol_pend <= 1'b1;
            end
            if (w_acc) begin
                r_in_x  <= w_in_x + X_W'(1);
                r_phase <= w_drop ? '0 : w_phase + X_W'(1);
                if (w_keep && (w_out_x != OUT_LAST)) begin
                    r_out_x <= w_out_x + X_W'(1);
                end else begin
                    r_out_x <= w_out_x;
                end
            end
        end
    end

`ifdef YUV422_HDECIM_AVG_EN
    logic           r_hold_v;
    ycbcr_t         r_hold;
    logic [X_W-1:0] r_hold_x;
    logic           w_flush;
    logic [8:0]     w_sum;

    // The held pixel leaves on the next valid input, a line start, or end of active input.
    assign w_flush = r_hold_v && (w_acc || iSOL || (r_in_x >= IN_LIM));
    assign w_sum   = {1'b0, r_hold.y} + {1'b0, w_pix.y} + 9'd1;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oYCbCr     <= '0;
            oDVAL      <= 1'b0;
            oX         <= '0;
            oLINE_DONE <= 1'b0;
            r_hold_v   <= 1'b0;
            r_hold     <= '0;
            r_hold_x   <= '0;
        end else begin
            oDVAL      <= w_flush;
            oLINE_DONE <= w_flush && (r_hold_x == OUT_LAST);
            if (w_flush) begin
                oYCbCr <= {((w_acc && w_drop) ? w_sum[8:1] : r_hold.y), r_hold.c};
                oX     <= r_hold_x;
            end
            if (w_keep) begin
                r_hold_v <= 1'b1;
                r_hold   <= {w_pix.y, w_c};
                r_hold_x <= w_out_x;
            end else if (w_flush) begin
                r_hold_v <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oYCbCr     <= '0;
            oDVAL      <= 1'b0;
            oX         <= '0;
            oLINE_DONE <= 1'b0;
        end else begin
            oDVAL      <= w_keep;
            oLINE_DONE <= w_keep && (w_out_x == OUT_LAST);
            if (w_keep) begin
                oYCbCr <= {w_pix.y, w_c};
                oX     <= w_out_x;
            end
        end
    end
`endif
endmodule

// File: tb/tb_yuv422_hdecim.sv
// Self-checking bench for yuv422_hdecim (default build): line-level reference model plus directed lines.
module tb_yuv422_hdecim;
    logic        clk = 1'b0;
    logic        rst;
    logic        sol;
    logic        dval;
    logic [15:0] din;
    logic [15:0] dout;
    logic        odval;
    logic [9:0]  ox;
    logic        done;

    yuv422_hdecim dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iSOL       (sol),
        .iDVAL      (dval),
        .iYCbCr     (din),
        .oYCbCr     (dout),
        .oDVAL      (odval),
        .oX         (ox),
        .oLINE_DONE (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] y;
        logic [7:0] c;
        int         x;
        bit         last;
    } exp_t;

    exp_t       q[$];
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_out  = 0;
    int         n_done = 0;
    int         done_x = -1;
    logic [7:0] got_y[0:1023];
    logic [7:0] got_c[0:1023];
    logic [7:0] line_c[0:1023];
    int         m_k    = 0;
    bit         m_pend = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Compare process: every cycle, outputs must match the model's schedule exactly.
    always @(posedge clk) begin
        exp_t e;
        bit   ev;
        #1;
        cyc++;
        ev = (q.size() > 0) && (q[0].cyc == cyc);
        chk("odval", {31'd0, odval}, {31'd0, ev});
        if (ev) begin
            e = q.pop_front();
            if (odval) begin
                chk("y", {24'd0, dout[15:8]}, {24'd0, e.y});
                chk("c", {24'd0, dout[7:0]}, {24'd0, e.c});
                chk("ox", {22'd0, ox}, e.x);
            end
            chk("line_done", {31'd0, done}, {31'd0, e.last});
        end else begin
            chk("line_done_idle", {31'd0, done}, 32'd0);
        end
        if (odval) begin
            got_y[ox] = dout[15:8];
            got_c[ox] = dout[7:0];
            n_out++;
            if (done) begin
                n_done++;
                done_x = int'(ox);
            end
        end
    end

    // Drive one cycle and advance the line-level model: kept pixel k lands at output
    // index k - (k+1)/9; chroma passes when parities agree, else takes input k-1.
    task automatic px(input bit s, input bit v, input logic [7:0] y, input logic [7:0] c);
        exp_t e;
        int   j;
        @(negedge clk);
        sol  = s;
        dval = v;
        din  = {y, c};
        if (s && !v) m_pend = 1;
        if (v) begin
            if (s || m_pend) m_k = 0;
            m_pend = 0;
            if (m_k < 720) begin
                line_c[m_k] = c;
                if (m_k % 9 != 8) begin
                    j      = m_k - (m_k + 1) / 9;
                    e.cyc  = cyc + 1;
                    e.y    = y;
                    e.c    = ((m_k % 2) == (j % 2)) ? c : ((m_k == 0) ? 8'h80 : line_c[m_k - 1]);
                    e.x    = j;
                    e.last = (j == 639);
                    q.push_back(e);
                end
                m_k++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 8'h00, 8'h00);
    endtask

    // cmode 0: Cb=0x10 / Cr=0x20; cmode 1: random chroma. sol_mode 0: none, 1: coincident, 2: preceding.
    task automatic send_line(input int n, input int gap, input int cmode, input int sol_mode);
        logic [7:0] c;
        if (sol_mode == 2) px(1, 0, 8'h00, 8'h00);
        for (int k = 0; k < n; k++) begin
            c = (cmode == 0) ? ((k % 2 == 1) ? 8'h20 : 8'h10) : 8'($urandom_range(0, 255));
            px((sol_mode == 1) && (k == 0), 1, 8'(k), c);
            idle(gap);
        end
    endtask

    task automatic clear_counts();
        n_out  = 0;
        n_done = 0;
        done_x = -1;
    endtask

    initial begin
        int bad;
        rst  = 1'b1;
        sol  = 1'b0;
        dval = 1'b0;
        din  = '0;
        #2;
        chk("reset_odval", {31'd0, odval}, 32'd0);
        chk("reset_data", {16'd0, dout}, 32'd0);
        chk("reset_ox", {22'd0, ox}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Ramp line with fixed Cb/Cr pattern
        clear_counts();
        send_line(720, 0, 0, 1);
        idle(3);
        chk("ramp_count", n_out, 640);
        chk("ramp_done_count", n_done, 1);
        chk("ramp_done_x", done_x, 639);
        chk("ramp_y7", {24'd0, got_y[7]}, 7);
        chk("ramp_y8", {24'd0, got_y[8]}, 9);
        chk("ramp_y639", {24'd0, got_y[639]}, 206);
        chk("ramp_c0", {24'd0, got_c[0]}, 32'h10);
        chk("ramp_c9", {24'd0, got_c[9]}, 32'h20);
        bad = 0;
        for (int i = 0; i < 640; i++)
            if (got_c[i] !== ((i % 2 == 1) ? 8'h20 : 8'h10)) bad++;
        chk("chroma_pattern", bad, 0);

        // Gapped valid (1 in 3), random chroma, iSOL one cycle ahead
        clear_counts();
        send_line(720, 2, 1, 2);
        idle(3);
        chk("gap_count", n_out, 640);
        chk("gap_done_count", n_done, 1);
        chk("gap_y8", {24'd0, got_y[8]}, 9);
        chk("gap_c8_subst", {24'd0, got_c[8]}, {24'd0, line_c[8]});

        // Overlong line
        clear_counts();
        send_line(800, 0, 1, 1);
        idle(3);
        chk("long_count", n_out, 640);
        chk("long_done_count", n_done, 1);

        // Short line
        clear_counts();
        send_line(100, 0, 1, 1);
        idle(3);
        chk("short_count", n_out, 89);
        chk("short_done_count", n_done, 0);

        // Mid-line async reset at X=300
        clear_counts();
        send_line(300, 0, 1, 1);
        @(negedge clk);
        rst  = 1'b1;
        dval = 1'b0;
        sol  = 1'b0;
        #1;
        chk("midrst_odval", {31'd0, odval}, 32'd0);
        chk("midrst_data", {16'd0, dout}, 32'd0);
        chk("midrst_ox", {22'd0, ox}, 32'd0);
        m_k    = 0;
        m_pend = 0;
        chk("midrst_queue", q.size(), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        chk("midrst_count", n_out, 267);

        // Mid-line iSOL at X=400, then a full line
        clear_counts();
        send_line(400, 0, 1, 1);
        send_line(720, 0, 1, 1);
        idle(3);
        chk("resync_count", n_out, 996);
        chk("resync_done_count", n_done, 1);
        chk("resync_c0", {24'd0, got_c[0]}, {24'd0, line_c[0]});

        idle(4);
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/yuv422_hdecim.md
Name: yuv422_hdecim

Overview:
- Horizontal 720→640 decimator for the ITU-R 656 YUV 4:2:2 pixel stream.
- Sits between the ITU-656 decoder output and the SDRAM frame-buffer write port (WR1), clocked by the 27 MHz TV-decoder clock.
- Drops one pixel in every 9 and re-aligns the Cb/Cr chroma alternation so the output stays a legal 4:2:2 stream.
- It replaces the external divider plus the Cb/Cr-swap arrangement.

Parameters:
- IN_WIDTH, 720: active input pixels per line; valid pixels beyond this are discarded.
- DROP_PERIOD, 9: one pixel dropped per DROP_PERIOD inputs; the drop is at phase DROP_PERIOD-1.
- OUT_WIDTH, 640: expected output pixels per line; must equal IN_WIDTH*(DROP_PERIOD-1)/DROP_PERIOD.

Ports:
- iCLK  in  1  pixel clock (TD_CLK, 27 MHz)
- iRST  in  1  asynchronous reset, active-high
- iSOL  in  1  start-of-line pulse, one cycle, precedes or coincides with the first valid pixel
- iDVAL  in  1  input pixel valid
- iYCbCr  in  16  {Y[15:8], C[7:0]}; C is Cb at even input X and Cr at odd input X
- oYCbCr  out  16  {Y, C}; C is Cb at even oX and Cr at odd oX
- oDVAL  out  1  output pixel valid
- oX  out  10  output pixel index 0..OUT_WIDTH-1
- oLINE_DONE  out  1  one-cycle pulse when output pixel OUT_WIDTH-1 is emitted

Behaviour:
- Reset (async, iRST=1): oYCbCr=0, oDVAL=0, oX=0, oLINE_DONE=0; input X counter, phase counter, output counter, held Cb and held Cr (0x80) all cleared/initialised.
- Counters:
  - in_x (10b) counts accepted valid pixels and saturates at IN_WIDTH; pixels with in_x ≥ IN_WIDTH are ignored.
  - phase counts 0..DROP_PERIOD-1 and wraps.
- Drop rule: a valid input with phase==DROP_PERIOD-1 is dropped, producing no output. Its chroma still updates the held Cb/Cr registers.
- Chroma realign:
  - Each valid input updates held_cb when in_x is even, and held_cr when in_x is odd.
  - Output chroma type is set by out_x[0] (0=Cb, 1=Cr).
  - If the input chroma type matches, pass it through; otherwise substitute the held register of the required type, as it was before this cycle's update.
- Latency: 1 clock from an accepted, kept input to oDVAL=1. oDVAL is low on every other cycle; there is no backpressure.
- Output counter: oX is the index of the pixel on oYCbCr. It increments after each emitted pixel and saturates at OUT_WIDTH-1. oLINE_DONE is asserted together with oDVAL for oX=OUT_WIDTH-1.
- iSOL: on the following accepted pixel, in_x, phase and out_x restart from 0 and held Cb/Cr are reset to 0x80.
  - If iSOL coincides with iDVAL, that pixel is X=0.
  - iSOL in mid-line aborts the line silently; no oLINE_DONE is generated.
- Short line (fewer than IN_WIDTH inputs): emit what arrives; no oLINE_DONE.
- All arithmetic is unsigned; no widths exceed 10 bits apart from data.

Optional Feature:
- Macro: YUV422_HDECIM_AVG_EN.
- Defined:
  - Output is held one kept pixel deep.
  - The kept pixel immediately preceding a dropped pixel outputs Y=(Y_prev+Y_drop+1)>>1, using a 9-bit sum; chroma is unchanged.
  - Latency becomes "emitted on the cycle after the next valid input".
  - On iSOL, or when in_x reaches IN_WIDTH, the held pixel is flushed on the next cycle.
- Undefined: Y of kept pixels passes through unmodified; latency is 1 clock.

Decomposition:
- Package yuv422_pkg holds:
  - constants: TV_IN_WIDTH=720, VGA_OUT_WIDTH=640, CHROMA_NEUTRAL=8'h80, X_W=10;
  - a packed typedef ycbcr_t {logic [7:0] y; logic [7:0] c;}.
- Natural sub-module: yuv422_chroma_realign. It holds the held Cb/Cr registers and the substitution mux. Inputs are in_x[0], out_x[0], a valid strobe and C; output is the realigned C.

Test Plan:
- Ramp line: iSOL, then 720 valid pixels with Y=in_x[7:0] → exactly 640 oDVAL; input X=8,17,26,… are absent from the Y sequence; oX runs 0..639; oLINE_DONE pulses once, with oX=639.
- Chroma: input C=0x10 at even X (Cb) and 0x20 at odd X (Cr) → every output with oX even has C=0x10 and every output with oX odd has C=0x20, across all 80 drop points.
- Gapped valid: iDVAL asserted 1-in-3 cycles for a full line → identical output sequence to the ramp test; every output lands 1 clock after its kept input.
- Overlong line: 800 valid pixels → 640 outputs only; inputs 720..799 produce nothing; counters hold.
- Mid-line reset and re-sync:
  - iRST pulsed at input X=300 → outputs return to 0 immediately and no oDVAL follows until input restarts.
  - iSOL at X=400 → next pixel outputs oX=0 and chroma restarts at Cb, with held values 0x80 where substitution is needed.
- With YUV422_HDECIM_AVG_EN: Y sequence 10,20,…,90 (X=0..8) → output X=7 has Y=(80+90+1)>>1=85 and X=8 is dropped; a trailing held pixel flushes after iSOL.
